// File: rtl/uart_bus_master_if.sv
// Signal bundle between the UART bus master and its environment:
// UART byte stream, arbiter handshake, FemtoRV32 memory port and status flags.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        busy;
    logic        frame_err;

    modport master (
        input  rx_data, rx_valid, tx_busy, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
        output tx_data, tx_start, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
               busy, frame_err
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
        input  tx_data, tx_start, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
               busy, frame_err
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes R/W frames, performs one 32-bit access
// on the memory bus after arbitration, and replies over the UART transmitter.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  CMD_READ       = 8'h52,
    parameter logic [7:0]  CMD_WRITE      = 8'h57
) (
    input  logic                  clk,
    input  logic                  resetn,
    uart_bus_master_if.master     bus
);

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  REPLY_ERR    = 8'h3F;
    localparam logic [7:0]  REPLY_ACK    = 8'h4B;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, REQ, WR_STB, WR_WAIT, RD_STB, RD_WAIT, SEND
    } state_t;

    state_t      state, state_nx;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] timer;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;
    logic [31:0] reply_sr;
    logic [2:0]  bytes_left;
    logic        tx_pending;   // byte handed to transmitter, waiting for tx_busy to fall

    logic is_cmd, in_frame, bus_phase, timeout_hit;

    always_comb begin
        is_cmd      = (bus.rx_data == CMD_READ) || (bus.rx_data == CMD_WRITE);
        in_frame    = (state == GET_ADDR) || (state == GET_DATA);
        bus_phase   = state inside {REQ, WR_STB, WR_WAIT, RD_STB, RD_WAIT};
        // An accepted byte in the expiry cycle wins over the timeout
        timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !bus.rx_valid
                      && (timer == TIMEOUT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // NOTE: the default at the top of this block keeps every path assigned,
    // so no latch is inferred for state_nx.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.rx_valid) state_nx = is_cmd ? GET_ADDR : SEND;
            GET_ADDR: if (bus.rx_valid && byte_cnt == 2'd3) state_nx = is_write ? GET_DATA : REQ;
                      else if (timeout_hit) state_nx = IDLE;
            GET_DATA: if (bus.rx_valid && byte_cnt == 2'd3) state_nx = REQ;
                      else if (timeout_hit) state_nx = IDLE;
            REQ:      if (bus.bus_gnt) state_nx = is_write ? WR_STB : RD_STB;
            WR_STB:   state_nx = WR_WAIT;
            WR_WAIT:  if (!bus.mem_wbusy) state_nx = SEND;
            RD_STB:   state_nx = RD_WAIT;
            RD_WAIT:  if (!bus.mem_rbusy) state_nx = SEND;
            SEND:     if (tx_pending && !bus.tx_busy && bytes_left == 3'd1) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req   = bus_phase;
        bus.mem_addr  = bus_phase ? {addr_sr[31:2], 2'b00} : 32'h0;
        bus.mem_wdata = bus_phase ? data_sr : 32'h0;
        bus.mem_wmask = (state == WR_STB) ? 4'hF : 4'h0;
        bus.mem_rstrb = (state == RD_STB);
        bus.tx_start  = (state == SEND) && !tx_pending && !bus.tx_busy;
        bus.tx_data   = reply_sr[31:24];
        bus.busy      = (state != IDLE);
        bus.frame_err = timeout_hit || (bus.rx_valid && !(state inside {IDLE, GET_ADDR, GET_DATA}));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            timer      <= 32'd0;
            addr_sr    <= 32'h0;
            data_sr    <= 32'h0;
            reply_sr   <= 32'h0;
            bytes_left <= 3'd0;
            tx_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.rx_valid) begin
                    if (is_cmd) begin
                        is_write <= (bus.rx_data == CMD_WRITE);
                        byte_cnt <= 2'd0;
                        timer    <= 32'd0;
                        addr_sr  <= 32'h0;
                        data_sr  <= 32'h0;
                    end else begin
                        reply_sr   <= {REPLY_ERR, 24'h0};
                        bytes_left <= 3'd1;
                        tx_pending <= 1'b0;
                    end
                end
                GET_ADDR, GET_DATA: if (bus.rx_valid) begin
                    if (state == GET_ADDR) addr_sr <= {addr_sr[23:0], bus.rx_data};
                    else                   data_sr <= {data_sr[23:0], bus.rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    timer    <= 32'd0;
                end else begin
                    timer <= timer + 32'd1;
                end
                WR_WAIT: if (!bus.mem_wbusy) begin
                    reply_sr   <= {REPLY_ACK, 24'h0};
                    bytes_left <= 3'd1;
                    tx_pending <= 1'b0;
                end
                RD_WAIT: if (!bus.mem_rbusy) begin
                    reply_sr   <= bus.mem_rdata;
                    bytes_left <= 3'd4;
                    tx_pending <= 1'b0;
                end
                SEND: begin
                    // tx_data stays on reply_sr[31:24] until the transmitter is done with it
                    if (!tx_pending) begin
                        if (!bus.tx_busy) tx_pending <= 1'b1;
                    end else if (!bus.tx_busy) begin
                        tx_pending <= 1'b0;
                        reply_sr   <= {reply_sr[23:0], 8'h00};
                        bytes_left <= bytes_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: reactive UART/arbiter/memory environment plus a
// frame-level reference model of expected replies and bus accesses.
module tb_uart_bus_master;

    localparam int TO = 100;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_bus_master_if bus_if();

    uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // environment knobs
    int gnt_delay = 0, rbusy_cycles = 0, wbusy_cycles = 0, tx_max = 3;
    // environment state and observations
    int cyc = 0, gnt_cnt = 0, rd_left = 0, wr_left = 0, tx_left = 0;
    logic gnt_q = 1'b0;
    logic [7:0]  tx_hold = 8'h0;
    logic [31:0] rd_val = 32'h0;
    byte_q_t     tx_q;
    logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$];
    int req_cycles = 0, ferr_cnt = 0, first_req_cyc = -1;
    int wstrb_cyc = 0, last_tx_cyc = 0, ferr_cyc = 0, last_rx_cyc = 0;
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A0F_C3A5;
    endfunction

    // Environment: inputs change on the falling edge, outputs are sampled 1ns later
    initial begin : responder
        bus_if.rx_data   = 8'h0;
        bus_if.rx_valid  = 1'b0;
        bus_if.tx_busy   = 1'b0;
        bus_if.bus_gnt   = 1'b0;
        bus_if.mem_rdata = 32'h0;
        bus_if.mem_rbusy = 1'b0;
        bus_if.mem_wbusy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus_if.tx_busy   = (tx_left > 0);
            bus_if.bus_gnt   = gnt_q;
            bus_if.mem_rbusy = (rd_left > 0);
            bus_if.mem_rdata = (rd_left > 0) ? $urandom : rd_val;
            bus_if.mem_wbusy = (wr_left > 0);
            #1;
            if (!resetn) begin
                tx_left = 0; gnt_q = 1'b0; rd_left = 0; wr_left = 0;
            end else begin
                if (bus_if.rx_valid) last_rx_cyc = cyc;
                if (bus_if.tx_start) begin
                    total++;
                    if (bus_if.tx_busy !== 1'b0) begin
                        bad++; $display("FAIL tx_start_while_busy got tx_busy=%b want 0", bus_if.tx_busy);
                    end
                    tx_q.push_back(bus_if.tx_data);
                    tx_hold     = bus_if.tx_data;
                    tx_left     = $urandom_range(tx_max, 1);
                    last_tx_cyc = cyc;
                end else if (tx_left > 0) begin
                    total++;
                    if (bus_if.tx_data !== tx_hold) begin
                        bad++; $display("FAIL tx_data_stable got=%h want=%h", bus_if.tx_data, tx_hold);
                    end
                    tx_left--;
                end
                if (!bus_if.bus_req) begin
                    gnt_q = 1'b0; gnt_cnt = gnt_delay;
                end else begin
                    req_cycles++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    if (!gnt_q) begin
                        if (gnt_cnt == 0) gnt_q = 1'b1;
                        else gnt_cnt--;
                    end
                end
                if (bus_if.mem_rstrb) begin
                    total++;
                    if (bus_if.bus_gnt !== 1'b1) begin
                        bad++; $display("FAIL rstrb_without_gnt got gnt=%b want 1", bus_if.bus_gnt);
                    end
                    rd_addr_q.push_back(bus_if.mem_addr);
                    rd_val  = env_mem.exists(bus_if.mem_addr) ? env_mem[bus_if.mem_addr]
                                                              : mem_default(bus_if.mem_addr);
                    rd_left = rbusy_cycles;
                end else if (rd_left > 0) rd_left--;
                if (bus_if.mem_wmask != 4'h0) begin
                    total++;
                    if (bus_if.bus_gnt !== 1'b1 || bus_if.mem_wmask !== 4'hF) begin
                        bad++; $display("FAIL wstrb_check got gnt=%b mask=%h want 1/F", bus_if.bus_gnt, bus_if.mem_wmask);
                    end
                    wr_addr_q.push_back(bus_if.mem_addr);
                    wr_data_q.push_back(bus_if.mem_wdata);
                    env_mem[bus_if.mem_addr] = bus_if.mem_wdata;
                    wr_left   = wbusy_cycles;
                    wstrb_cyc = cyc;
                end else if (wr_left > 0) wr_left--;
                if (bus_if.frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
            end
        end
    end

    function automatic byte_q_t make_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        byte_q_t q;
        q = {wr ? 8'h57 : 8'h52, addr[31:24], addr[23:16], addr[15:8], addr[7:0]};
        if (wr) q = {q, data[31:24], data[23:16], data[15:8], data[7:0]};
        return q;
    endfunction

    // Reference: a write is acknowledged with 'K', a read returns the word MSB first
    function automatic byte_q_t ref_reply(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a, d;
        a = {addr[31:2], 2'b00};
        if (wr) begin
            ref_mem[a] = data;
            return {8'h4B};
        end
        d = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
        return {d[31:24], d[23:16], d[15:8], d[7:0]};
    endfunction

    task automatic clear_env();
        tx_q.delete(); rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        req_cycles = 0; first_req_cyc = -1;
    endtask

    task automatic send_frame(input byte_q_t f, input int max_gap);
        foreach (f[i]) begin
            @(negedge clk);
            bus_if.rx_data  = f[i];
            bus_if.rx_valid = 1'b1;
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                bus_if.rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        #2;
        while ((bus_if.busy || bus_if.tx_busy) && n < limit) begin
            @(negedge clk); #2; n++;
        end
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL %s idle_timeout busy=%b want 0", name, bus_if.busy);
        end
    endtask

    task automatic check_tx(input string name, input byte_q_t exp);
        total++;
        if (tx_q.size() != exp.size()) begin
            bad++; $display("FAIL %s tx_count got=%0d want=%0d", name, tx_q.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (tx_q[i] !== exp[i]) begin
                    bad++; $display("FAIL %s tx_byte%0d got=%h want=%h", name, i, tx_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_access(input string name, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        total++;
        if (wr) begin
            if (wr_addr_q.size() != 1 || rd_addr_q.size() != 0) begin
                bad++; $display("FAIL %s strobe_count got wr=%0d rd=%0d want 1/0", name, wr_addr_q.size(), rd_addr_q.size());
            end else begin
                total += 2;
                if (wr_addr_q[0] !== a) begin bad++; $display("FAIL %s waddr got=%h want=%h", name, wr_addr_q[0], a); end
                if (wr_data_q[0] !== data) begin bad++; $display("FAIL %s wdata got=%h want=%h", name, wr_data_q[0], data); end
            end
        end else begin
            if (rd_addr_q.size() != 1 || wr_addr_q.size() != 0) begin
                bad++; $display("FAIL %s strobe_count got rd=%0d wr=%0d want 1/0", name, rd_addr_q.size(), wr_addr_q.size());
            end else begin
                total++;
                if (rd_addr_q[0] !== a) begin bad++; $display("FAIL %s raddr got=%h want=%h", name, rd_addr_q[0], a); end
            end
        end
    endtask

    task automatic do_access(input string name, input bit wr, input logic [31:0] addr, input logic [31:0] data, input int gap);
        byte_q_t f, e;
        f = make_frame(wr, addr, data);
        e = ref_reply(wr, addr, data);
        clear_env();
        send_frame(f, gap);
        wait_idle(name, 600);
        check_tx(name, e);
        check_access(name, wr, addr, data);
    endtask

    task automatic check_outputs_zero(input string name);
        total += 3;
        if ({bus_if.busy, bus_if.bus_req, bus_if.tx_start, bus_if.mem_rstrb, bus_if.frame_err} !== 5'b0) begin
            bad++; $display("FAIL %s ctrl got=%b want 00000", name,
                {bus_if.busy, bus_if.bus_req, bus_if.tx_start, bus_if.mem_rstrb, bus_if.frame_err});
        end
        if ({bus_if.mem_addr, bus_if.mem_wdata} !== 64'h0) begin
            bad++; $display("FAIL %s addr_wdata got=%h/%h want 0", name, bus_if.mem_addr, bus_if.mem_wdata);
        end
        if ({bus_if.tx_data, bus_if.mem_wmask} !== 12'h0) begin
            bad++; $display("FAIL %s txdata_wmask got=%h/%h want 0", name, bus_if.tx_data, bus_if.mem_wmask);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        do_access("write_directed", 1'b1, 32'h0042_0004, 32'h0000_0007, 0);
    endtask

    task automatic test_read();
        env_mem[32'h0000_0100] = 32'hDEAD_BEEF;
        ref_mem[32'h0000_0100] = 32'hDEAD_BEEF;
        rbusy_cycles = 3;
        do_access("read_directed", 1'b0, 32'h0000_0103, 32'h0, 0);
        check_tx("read_deadbeef", {8'hDE, 8'hAD, 8'hBE, 8'hEF});
        rbusy_cycles = 0;
    endtask

    task automatic test_bad_cmd();
        clear_env();
        send_frame({8'h11}, 0);
        wait_idle("bad_cmd", 200);
        check_tx("bad_cmd", {8'h3F});
        total++;
        if (req_cycles != 0 || rd_addr_q.size() != 0 || wr_addr_q.size() != 0) begin
            bad++; $display("FAIL bad_cmd bus_activity got req=%0d rd=%0d wr=%0d want 0", req_cycles, rd_addr_q.size(), wr_addr_q.size());
        end
    endtask

    task automatic test_timeout();
        int f0, n;
        f0 = ferr_cnt;
        clear_env();
        send_frame({8'h52, 8'h00, 8'h42}, 0);
        n = 0;
        while (ferr_cnt == f0 && n < TO + 20) begin @(negedge clk); #2; n++; end
        repeat (5) @(negedge clk);
        #2;
        total += 3;
        if (ferr_cnt != f0 + 1) begin
            bad++; $display("FAIL timeout ferr_count got=%0d want=%0d", ferr_cnt - f0, 1);
        end
        if (ferr_cyc - last_rx_cyc != TO) begin
            bad++; $display("FAIL timeout latency got=%0d want=%0d", ferr_cyc - last_rx_cyc, TO);
        end
        if (bus_if.busy !== 1'b0 || req_cycles != 0 || tx_q.size() != 0) begin
            bad++; $display("FAIL timeout aftermath got busy=%b req=%0d tx=%0d want 0", bus_if.busy, req_cycles, tx_q.size());
        end
        do_access("after_timeout", 1'b0, 32'h0000_0040, 32'h0, 1);
    endtask

    task automatic test_gnt_wbusy();
        gnt_delay = 10; wbusy_cycles = 5;
        do_access("gnt_wbusy", 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 0);
        total += 2;
        if (wstrb_cyc - first_req_cyc < 10) begin
            bad++; $display("FAIL gnt_delay strobe_after_req got=%0d want>=10", wstrb_cyc - first_req_cyc);
        end
        if (last_tx_cyc - wstrb_cyc <= 5) begin
            bad++; $display("FAIL wbusy_wait ack_after_strobe got=%0d want>5", last_tx_cyc - wstrb_cyc);
        end
        gnt_delay = 0; wbusy_cycles = 0;
    endtask

    task automatic test_overrun();
        byte_q_t f, e;
        int f0, n;
        tx_max = 6; rbusy_cycles = 2;
        f = make_frame(1'b0, 32'h0042_0004, 32'h0);
        e = ref_reply(1'b0, 32'h0042_0004, 32'h0);
        f0 = ferr_cnt;
        clear_env();
        send_frame(f, 0);
        n = 0;
        while (tx_q.size() < 1 && n < 200) begin @(negedge clk); #2; n++; end
        send_frame({8'h57}, 0);
        wait_idle("overrun", 600);
        check_tx("overrun", e);
        check_access("overrun", 1'b0, 32'h0042_0004, 32'h0);
        total++;
        if (ferr_cnt != f0 + 1) begin
            bad++; $display("FAIL overrun ferr_count got=%0d want=1", ferr_cnt - f0);
        end
        tx_max = 3; rbusy_cycles = 0;
    endtask

    task automatic test_random();
        int f0;
        f0 = ferr_cnt;
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] addr, data;
            logic [7:0] junk;
            gnt_delay    = $urandom_range(4, 0);
            rbusy_cycles = $urandom_range(4, 0);
            wbusy_cycles = $urandom_range(4, 0);
            tx_max       = $urandom_range(4, 1);
            kind = $urandom_range(7, 0);
            addr = {($urandom_range(1, 0) != 0) ? 8'h80 : 8'h00, 18'h0, 4'($urandom_range(15, 0)), 2'($urandom)};
            data = $urandom;
            if (kind == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h52 || junk == 8'h57) junk = 8'h00;
                clear_env();
                send_frame({junk}, 0);
                wait_idle("rand_junk", 200);
                check_tx("rand_junk", {8'h3F});
            end else begin
                do_access("rand_access", kind < 4, addr, data, 3);
            end
        end
        total++;
        if (ferr_cnt != f0) begin
            bad++; $display("FAIL random spurious_ferr got=%0d want=0", ferr_cnt - f0);
        end
        gnt_delay = 0; rbusy_cycles = 0; wbusy_cycles = 0; tx_max = 3;
    endtask

    task automatic test_reset_mid();
        int n;
        rbusy_cycles = 30;
        clear_env();
        send_frame(make_frame(1'b0, 32'h0000_0200, 32'h0), 0);
        n = 0;
        while (rd_addr_q.size() < 1 && n < 100) begin @(negedge clk); #2; n++; end
        repeat (3) @(negedge clk);
        total++;
        if (bus_if.bus_req !== 1'b1) begin
            bad++; $display("FAIL reset_mid in_wait got bus_req=%b want 1", bus_if.bus_req);
        end
        resetn = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        rbusy_cycles = 0;
        repeat (60) @(negedge clk);
        #2;
        total++;
        if (tx_q.size() != 0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid resumed got tx=%0d busy=%b want 0/0", tx_q.size(), bus_if.busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_gnt_wbusy();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
